// File: rtl/out_signature_monitor.sv
// out_signature_monitor: folds accepted scrambler output words into a MISR
// and reports a pass/fail verdict once a fixed window of words has been seen.
module out_signature_monitor #(
    parameter int               WIDTH    = 5,
    parameter int               WINDOW   = 10,
    parameter logic [0:WIDTH-1] SIG_INIT = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         in_valid,
    input  logic [0:WIDTH-1]             in_data,
    input  logic [0:WIDTH-1]             exp_sig,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [0:WIDTH-1]             sig,
    output logic [$clog2(WINDOW+1)-1:0]  count
);

    localparam int            CW   = $clog2(WINDOW + 1);
    localparam logic [CW-1:0] LAST = CW'(WINDOW);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [0:WIDTH-1] sig_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic             accept;

    // Next signature: same feedback taps as the upstream scrambler.
    always_comb begin
        sig_nxt    = '0;
        sig_nxt[0] = in_data[0] ^ sig[WIDTH-1];
        sig_nxt[1] = in_data[1] ^ sig[0] ^ sig[WIDTH-1];
        for (int i = 2; i < WIDTH; i++) begin
            sig_nxt[i] = in_data[i] ^ sig[i-1];
        end
    end

    // A start always wins, so the word presented with it is dropped.
    assign accept  = (state == S_RUN) && in_valid && !start;
    assign cnt_nxt = count + 1'b1;

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    // Window control, signature fold and end-of-window verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            sig   <= SIG_INIT;
            count <= '0;
            pass  <= 1'b0;
        end else if (start) begin
            state <= S_RUN;
            sig   <= SIG_INIT;
            count <= '0;
            pass  <= 1'b0;
        end else if (accept) begin
            sig   <= sig_nxt;
            count <= cnt_nxt;
            if (cnt_nxt == LAST) begin
                state <= S_DONE;
                pass  <= (sig_nxt == exp_sig);
            end
        end
    end

endmodule
